// File: rtl/osd_msg_source_pkg.sv
// Shared types and constants for the osd_msg_source character stream source.
// Channel FSM states, error counter width and the power-on message.
package osd_msg_source_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP,
    ST_DONE
  } chan_state_e;

  localparam int ERR_WIDTH = 16;

  // "Hello World!\n", first character in the least significant byte.
  localparam logic [127:0] DEFAULT_INIT_MSG = 128'h0000000a_21646c72_6f57206f_6c6c6548;

  function automatic logic [ERR_WIDTH-1:0] err_inc(input logic [ERR_WIDTH-1:0] v);
    return (&v) ? v : v + ERR_WIDTH'(1);
  endfunction

endpackage

// File: rtl/osd_msg_source_chan.sv
// One output channel of osd_msg_source: replay FSM with pointer, pass and gap counters,
// plus the loop-back checker built only when MSG_SOURCE_CHECK_EN is defined.
module osd_msg_source_chan
  import osd_msg_source_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int AW         = 4,
  parameter int GAP_WIDTH  = 8,
  parameter int REP_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic                  i_stop,
  input  logic [AW:0]           i_len,
  input  logic [GAP_WIDTH-1:0]  i_cfg_gap,
  input  logic [REP_WIDTH-1:0]  i_cfg_repeat,
  output logic [AW-1:0]         o_ptr,
  input  logic [DATA_WIDTH-1:0] i_rd_char,
  output logic [DATA_WIDTH-1:0] o_char,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_done,
  output logic                  o_busy,
  input  logic [DATA_WIDTH-1:0] i_in_char,
  input  logic                  i_in_valid,
  output logic [AW-1:0]         o_exp_ptr,
  input  logic [DATA_WIDTH-1:0] i_exp_char,
  output logic [ERR_WIDTH-1:0]  o_err_count
);

  localparam logic [AW:0]          LEN_ONE = (AW+1)'(1);
  localparam logic [AW-1:0]        PTR_ONE = AW'(1);
  localparam logic [GAP_WIDTH-1:0] GAP_ONE = GAP_WIDTH'(1);
  localparam logic [REP_WIDTH-1:0] REP_ONE = REP_WIDTH'(1);

  chan_state_e           r_state;
  logic [AW-1:0]         r_ptr;
  logic [REP_WIDTH-1:0]  r_pass;
  logic [GAP_WIDTH-1:0]  r_gap_cnt;
  logic                  r_valid;
  logic                  r_done;
  logic                  r_stop_pend;
  logic                  r_stalled;
  logic [DATA_WIDTH-1:0] r_char_hold;

  logic w_hs;
  logic w_last;
  logic w_endless;
  logic w_more;

  assign w_hs      = r_valid && i_ready;
  assign w_last    = ({1'b0, r_ptr} == (i_len - LEN_ONE));
  assign w_endless = &i_cfg_repeat;
  assign w_more    = w_endless || (r_pass < i_cfg_repeat);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_pass      <= '0;
      r_gap_cnt   <= '0;
      r_valid     <= 1'b0;
      r_done      <= 1'b0;
      r_stop_pend <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_stop_pend <= 1'b0;
          if (i_start) begin
            r_ptr  <= '0;
            r_pass <= '0;
            if (i_len == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_SEND;
              r_valid <= 1'b1;
            end
          end
        end
        ST_SEND: begin
          if (i_stop) begin
            r_stop_pend <= 1'b1;
          end
          if (w_hs) begin
            // A stop only takes effect once the beat already on the port is accepted.
            if (i_stop || r_stop_pend) begin
              r_state <= ST_IDLE;
              r_valid <= 1'b0;
            end else if (w_last && !w_more) begin
              r_state <= ST_DONE;
              r_valid <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              if (w_last) begin
                r_ptr <= '0;
                if (!w_endless) begin
                  r_pass <= r_pass + REP_ONE;
                end
              end else begin
                r_ptr <= r_ptr + PTR_ONE;
              end
              if (i_cfg_gap != '0) begin
                r_state   <= ST_GAP;
                r_valid   <= 1'b0;
                r_gap_cnt <= i_cfg_gap - GAP_ONE;
              end
            end
          end
        end
        ST_GAP: begin
          if (i_stop) begin
            r_state <= ST_IDLE;
          end else if (r_gap_cnt == '0) begin
            r_state <= ST_SEND;
            r_valid <= 1'b1;
          end else begin
            r_gap_cnt <= r_gap_cnt - GAP_ONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  // Freeze the presented character once a beat has been refused, so buffer writes cannot alter it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stalled   <= 1'b0;
      r_char_hold <= '0;
    end else begin
      r_stalled   <= r_valid && !i_ready;
      r_char_hold <= o_char;
    end
  end

  assign o_char  = r_stalled ? r_char_hold : i_rd_char;
  assign o_ptr   = r_ptr;
  assign o_valid = r_valid;
  assign o_done  = r_done;
  assign o_busy  = (r_state != ST_IDLE);

`ifdef MSG_SOURCE_CHECK_EN
  logic [AW-1:0]        r_exp_ptr;
  logic [ERR_WIDTH-1:0] r_err;
  logic                 w_exp_wrap;

  assign w_exp_wrap = (({1'b0, r_exp_ptr} + LEN_ONE) >= i_len);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exp_ptr <= '0;
      r_err     <= '0;
    end else begin
      if (i_in_valid && (i_in_char != i_exp_char)) begin
        r_err <= err_inc(r_err);
      end
      if (i_start && (r_state == ST_IDLE)) begin
        r_exp_ptr <= '0;
      end else if (i_in_valid) begin
        r_exp_ptr <= w_exp_wrap ? '0 : r_exp_ptr + PTR_ONE;
      end
    end
  end

  assign o_exp_ptr   = r_exp_ptr;
  assign o_err_count = r_err;
`else
  logic w_unused_chk;
  assign w_unused_chk = ^{i_in_char, i_in_valid, i_exp_char};
  assign o_exp_ptr    = '0;
  assign o_err_count  = '0;
`endif

endmodule

// File: rtl/osd_msg_source.sv
// Multi-channel message replay source: shared message buffer, length register and N_CH channels.
// Define MSG_SOURCE_CHECK_EN to build the per-channel loop-back checkers.
module osd_msg_source
  import osd_msg_source_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int N_CH       = 1,
  parameter int GAP_WIDTH  = 8,
  parameter int REP_WIDTH  = 4,
  parameter int INIT_LEN   = 13,
  parameter logic [DEPTH*DATA_WIDTH-1:0] INIT_MSG = (DEPTH*DATA_WIDTH)'(DEFAULT_INIT_MSG),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cfg_we,
  input  logic [AW-1:0]              cfg_addr,
  input  logic [DATA_WIDTH-1:0]      cfg_data,
  input  logic                       cfg_len_we,
  input  logic [AW:0]                cfg_len,
  input  logic [GAP_WIDTH-1:0]       cfg_gap,
  input  logic [REP_WIDTH-1:0]       cfg_repeat,
  output logic                       cfg_busy,
  input  logic [N_CH-1:0]            start,
  input  logic [N_CH-1:0]            stop,
  output logic [N_CH-1:0]            done,
  output logic [N_CH*DATA_WIDTH-1:0] out_char,
  output logic [N_CH-1:0]            out_valid,
  input  logic [N_CH-1:0]            out_ready,
  input  logic [N_CH*DATA_WIDTH-1:0] in_char,
  input  logic [N_CH-1:0]            in_valid,
  output logic [N_CH-1:0]            in_ready,
  output logic [N_CH*ERR_WIDTH-1:0]  err_count
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]           r_len;

  logic [AW-1:0]         w_ptr      [N_CH];
  logic [AW-1:0]         w_exp_ptr  [N_CH];
  logic [DATA_WIDTH-1:0] w_rd_char  [N_CH];
  logic [DATA_WIDTH-1:0] w_exp_char [N_CH];
  logic [N_CH-1:0]       w_busy;

  // Buffer entries are registers so that every channel gets its own combinational read port.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_mem[gi] <= INIT_MSG[gi*DATA_WIDTH +: DATA_WIDTH];
        end else if (cfg_we && (cfg_addr == AW'(gi))) begin
          r_mem[gi] <= cfg_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len <= (AW+1)'(INIT_LEN);
    end else if (cfg_len_we && !cfg_busy) begin
      r_len <= cfg_len;
    end
  end

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      assign w_rd_char[gi]  = r_mem[w_ptr[gi]];
      assign w_exp_char[gi] = r_mem[w_exp_ptr[gi]];
      assign in_ready[gi]   = 1'b1;

      osd_msg_source_chan #(
        .DATA_WIDTH (DATA_WIDTH),
        .AW         (AW),
        .GAP_WIDTH  (GAP_WIDTH),
        .REP_WIDTH  (REP_WIDTH)
      ) u_chan (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (start[gi]),
        .i_stop       (stop[gi]),
        .i_len        (r_len),
        .i_cfg_gap    (cfg_gap),
        .i_cfg_repeat (cfg_repeat),
        .o_ptr        (w_ptr[gi]),
        .i_rd_char    (w_rd_char[gi]),
        .o_char       (out_char[gi*DATA_WIDTH +: DATA_WIDTH]),
        .o_valid      (out_valid[gi]),
        .i_ready      (out_ready[gi]),
        .o_done       (done[gi]),
        .o_busy       (w_busy[gi]),
        .i_in_char    (in_char[gi*DATA_WIDTH +: DATA_WIDTH]),
        .i_in_valid   (in_valid[gi]),
        .o_exp_ptr    (w_exp_ptr[gi]),
        .i_exp_char   (w_exp_char[gi]),
        .o_err_count  (err_count[gi*ERR_WIDTH +: ERR_WIDTH])
      );
    end
  endgenerate

  assign cfg_busy = |w_busy;

endmodule

// File: tb/tb_osd_msg_source.sv
// Directed bench for osd_msg_source with two channels: replay, stalls, gaps/repeats,
// zero length, stop, mid-stream reset and the loop-back checker.
`timescale 1ns/1ps
module tb_osd_msg_source;

  localparam int DW  = 8;
  localparam int NCH = 2;
  localparam int AW  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              cfg_we = 1'b0;
  logic [AW-1:0]     cfg_addr = '0;
  logic [DW-1:0]     cfg_data = '0;
  logic              cfg_len_we = 1'b0;
  logic [AW:0]       cfg_len = '0;
  logic [7:0]        cfg_gap = '0;
  logic [3:0]        cfg_repeat = '0;
  logic              cfg_busy;
  logic [NCH-1:0]    start = '0;
  logic [NCH-1:0]    stop = '0;
  logic [NCH-1:0]    done;
  logic [NCH*DW-1:0] out_char;
  logic [NCH-1:0]    out_valid;
  logic [NCH-1:0]    out_ready = '0;
  logic [NCH*DW-1:0] in_char;
  logic [NCH-1:0]    in_valid;
  logic [NCH-1:0]    in_ready;
  logic [NCH*16-1:0] err_count;

  osd_msg_source #(.N_CH(NCH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_len_we(cfg_len_we), .cfg_len(cfg_len), .cfg_gap(cfg_gap), .cfg_repeat(cfg_repeat),
    .cfg_busy(cfg_busy), .start(start), .stop(stop), .done(done),
    .out_char(out_char), .out_valid(out_valid), .out_ready(out_ready),
    .in_char(in_char), .in_valid(in_valid), .in_ready(in_ready), .err_count(err_count)
  );

  logic [7:0] exp_msg [13] = '{8'h48, 8'h65, 8'h6c, 8'h6c, 8'h6f, 8'h20, 8'h57,
                              8'h6f, 8'h72, 8'h6c, 8'h64, 8'h21, 8'h0a};

`ifdef MSG_SOURCE_CHECK_EN
  localparam int EXP_ERR = 1;
`else
  localparam int EXP_ERR = 0;
`endif

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // loop-back: channel 0 output into the checker, beat 5 corrupted to 8'h00
  logic loop_en = 1'b0;
  logic lb_clr = 1'b0;
  int   lb_idx = 0;
  always @(posedge clk) begin
    if (lb_clr) lb_idx <= 0;
    else if (in_valid[0]) lb_idx <= lb_idx + 1;
  end
  always_comb begin
    in_valid = '0;
    in_char  = '0;
    if (loop_en) begin
      in_valid[0]   = out_valid[0] & out_ready[0];
      in_char[7:0]  = (lb_idx == 5) ? 8'h00 : out_char[7:0];
    end
  end

  // observer at the falling edge
  int cyc = 0;
  int n_beats [NCH];
  int n_done [NCH];
  int space_err [NCH];
  int exp_space [NCH];
  int first_cyc [NCH];
  int last_cyc [NCH];
  int done_cyc [NCH];
  int start_cyc [NCH];
  logic [NCH-1:0] prev_stall = '0;
  logic [7:0] prev_char [NCH];

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        if (start[c]) start_cyc[c] = cyc;
        if (prev_stall[c]) begin
          chk($sformatf("ch%0d stall valid", c), 32'(out_valid[c]), 32'd1);
          chk($sformatf("ch%0d stall char", c), 32'(out_char[c*DW +: DW]), 32'(prev_char[c]));
        end
        prev_stall[c] = out_valid[c] && !out_ready[c];
        prev_char[c]  = out_char[c*DW +: DW];
        if (out_valid[c] && out_ready[c]) begin
          $display("ch%0d beat %0d char %02h cycle %0d", c, n_beats[c], out_char[c*DW +: DW], cyc);
          chk($sformatf("ch%0d beat%0d char", c, n_beats[c]), 32'(out_char[c*DW +: DW]),
              32'(exp_msg[n_beats[c] % 13]));
          if (n_beats[c] == 0) first_cyc[c] = cyc;
          else if (cyc - last_cyc[c] != exp_space[c]) space_err[c]++;
          last_cyc[c] = cyc;
          n_beats[c]++;
        end
        if (done[c]) begin
          n_done[c]++;
          done_cyc[c] = cyc;
        end
      end
    end else begin
      prev_stall = '0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    for (int c = 0; c < NCH; c++) begin
      n_beats[c] = 0; n_done[c] = 0; space_err[c] = 0; exp_space[c] = 1;
      first_cyc[c] = -1; last_cyc[c] = -1; done_cyc[c] = -1; start_cyc[c] = -1;
    end
  endtask

  task automatic wait_done(input int c, input int budget);
    for (int t = 0; t < budget && n_done[c] == 0; t++) tick();
  endtask

  typedef struct {
    int gap;
    int rep;
    int rdy_mode;
    int exp_beats;
    int exp_space;
  } vec_t;
  vec_t vecs [4];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{gap: 0, rep: 0, rdy_mode: 0, exp_beats: 13, exp_space: 1};
    vecs[1] = '{gap: 0, rep: 0, rdy_mode: 1, exp_beats: 13, exp_space: 3};
    vecs[2] = '{gap: 3, rep: 1, rdy_mode: 0, exp_beats: 26, exp_space: 4};
    vecs[3] = '{gap: 1, rep: 2, rdy_mode: 0, exp_beats: 39, exp_space: 2};
    clear_mon();

    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset cfg_busy", 32'(cfg_busy), 32'd0);
    chk("reset err_count", err_count, 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd3);
    chk("reset out_char", 32'(out_char[7:0]), 32'h48);

    // buffer write visible on the idle channel next cycle, then restored
    cfg_we = 1'b1; cfg_addr = 4'd0; cfg_data = 8'h4a;
    tick();
    cfg_we = 1'b0;
    chk("cfg_we visible", 32'(out_char[7:0]), 32'h4a);
    cfg_we = 1'b1; cfg_data = 8'h48;
    tick();
    cfg_we = 1'b0;

    // table-driven replay scenarios on channel 0
    for (int v = 0; v < 4; v++) begin
      cfg_gap = 8'(vecs[v].gap);
      cfg_repeat = 4'(vecs[v].rep);
      clear_mon();
      exp_space[0] = vecs[v].exp_space;
      out_ready[0] = (vecs[v].rdy_mode == 0);
      start[0] = 1'b1;
      tick();
      start[0] = 1'b0;
      for (int t = 0; t < 400 && n_done[0] == 0; t++) begin
        if (vecs[v].rdy_mode == 1) out_ready[0] = (t % 3 == 2);
        tick();
      end
      out_ready[0] = 1'b1;
      repeat (3) tick();
      chk($sformatf("vec%0d done count", v), 32'(n_done[0]), 32'd1);
      chk($sformatf("vec%0d beats", v), 32'(n_beats[0]), 32'(vecs[v].exp_beats));
      chk($sformatf("vec%0d spacing errors", v), 32'(space_err[0]), 32'd0);
      chk($sformatf("vec%0d done after last", v), 32'(done_cyc[0]), 32'(last_cyc[0] + 1));
      if (vecs[v].rdy_mode == 0)
        chk($sformatf("vec%0d first beat", v), 32'(first_cyc[0]), 32'(start_cyc[0] + 1));
      chk($sformatf("vec%0d idle busy", v), 32'(cfg_busy), 32'd0);
    end
    cfg_gap = '0;
    cfg_repeat = '0;

    // zero length: done next cycle, no beat
    cfg_len = '0; cfg_len_we = 1'b1;
    tick();
    cfg_len_we = 1'b0;
    clear_mon();
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    repeat (4) tick();
    chk("len0 beats", 32'(n_beats[0]), 32'd0);
    chk("len0 done count", 32'(n_done[0]), 32'd1);
    chk("len0 done cycle", 32'(done_cyc[0]), 32'(start_cyc[0] + 1));

    // length load ignored while busy
    cfg_len = 5'd13; cfg_len_we = 1'b1;
    tick();
    cfg_len_we = 1'b0;
    clear_mon();
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    tick();
    chk("busy during send", 32'(cfg_busy), 32'd1);
    cfg_len = 5'd5; cfg_len_we = 1'b1;
    tick();
    cfg_len_we = 1'b0;
    wait_done(0, 100);
    tick();
    chk("len busy beats", 32'(n_beats[0]), 32'd13);
    chk("len busy done", 32'(n_done[0]), 32'd1);

    // two channels, stop ch0 mid-message while its beat is stalled
    clear_mon();
    out_ready = 2'b11;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    repeat (3) tick();
    start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    for (int t = 0; t < 100 && n_beats[0] < 6; t++) tick();
    out_ready[0] = 1'b0;
    stop[0] = 1'b1;
    tick();
    stop[0] = 1'b0;
    repeat (2) tick();
    chk("stop pending valid", 32'(out_valid[0]), 32'd1);
    out_ready[0] = 1'b1;
    wait_done(1, 100);
    repeat (3) tick();
    chk("stop ch0 beats", 32'(n_beats[0]), 32'd7);
    chk("stop ch0 no done", 32'(n_done[0]), 32'd0);
    chk("stop ch0 idle", 32'(out_valid[0]), 32'd0);
    chk("ch1 beats", 32'(n_beats[1]), 32'd13);
    chk("ch1 done", 32'(n_done[1]), 32'd1);
    chk("ch1 spacing errors", 32'(space_err[1]), 32'd0);
    chk("ch1 first beat", 32'(first_cyc[1]), 32'(start_cyc[1] + 1));

    // asynchronous reset in the middle of both streams
    clear_mon();
    start = 2'b11;
    tick();
    start = 2'b00;
    repeat (3) tick();
    chk("pre-reset valid", 32'(out_valid), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset valid", 32'(out_valid), 32'd0);
    chk("async reset busy", 32'(cfg_busy), 32'd0);
    chk("async reset done", 32'(done), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("post-reset valid", 32'(out_valid), 32'd0);
    chk("post-reset busy", 32'(cfg_busy), 32'd0);

    // loop-back checker with one corrupted character
    clear_mon();
    lb_clr = 1'b1;
    tick();
    lb_clr = 1'b0;
    loop_en = 1'b1;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    wait_done(0, 100);
    tick();
    loop_en = 1'b0;
    chk("loopback beats", 32'(n_beats[0]), 32'd13);
    chk("err_count ch0", 32'(err_count[15:0]), 32'(EXP_ERR));
    chk("err_count ch1", 32'(err_count[31:16]), 32'd0);
    chk("in_ready", 32'(in_ready), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
